// File: rtl/ivl_uvm_ovl_dec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_ctrl_pkg
// Shared types for the ovl_decrement stimulus sequencer: the controller state
// encoding and its enum. No ports.
// ---------------------------------------------------------------------------
package ivl_uvm_ovl_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    COUNT = ST_COUNT,
    DONE  = ST_DONE
  } dec_state_t;

endpackage

// File: rtl/ivl_uvm_ovl_dec_ctrl_if.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_dec_ctrl_if
// Bundles the sequencer's run controls and checker-facing outputs.
//   master : stimulus side (drives start/load_val/step/max_steps/pause/abort)
//   slave  : sequencer side (drives expr/chk_enable/busy/done/wrapped)
// ---------------------------------------------------------------------------
interface ivl_uvm_ovl_dec_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step;
  logic [CNT_W-1:0] max_steps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] expr;
  logic             chk_enable;
  logic             busy;
  logic             done;
  logic             wrapped;

  modport master (
    output start, load_val, step, max_steps, pause, abort,
    input  expr, chk_enable, busy, done, wrapped
  );

  modport slave (
    input  start, load_val, step, max_steps, pause, abort,
    output expr, chk_enable, busy, done, wrapped
  );

endinterface

// File: rtl/ivl_uvm_ovl_dec_ctrl_step_cnt.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_step_cnt
// Saturating step counter with a budget match.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (start of a run)
//   inc_i         : count one step
//   max_i         : step budget, 0 means unlimited
//   hit_o         : budget reached (never asserted when max_i is 0)
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_step_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] max_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      // Holds at all-ones instead of wrapping back to zero.
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_o = (max_i != '0) && (cnt_q == max_i);

endmodule

// File: rtl/ivl_uvm_ovl_dec_ctrl.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_dec_ctrl
// Drives a down-counting test expression into an ovl_decrement checker and
// qualifies it with chk_enable, which is dropped on every cycle where expr
// changes by anything other than a legal decrement (load, saturate, wrap).
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of ivl_uvm_ovl_dec_ctrl_if (run controls in,
//           expr/chk_enable/busy/done/wrapped out, all registered)
// Parameters: WIDTH (expr width), CNT_W (budget/counter width),
//             WRAP (0 = saturate at zero, 1 = wrap modulo 2^WIDTH).
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_dec_ctrl
  import ivl_uvm_ovl_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int WRAP  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  ivl_uvm_ovl_dec_ctrl_if.slave bus
);

  dec_state_t       state_q, state_d;
  logic [WIDTH-1:0] expr_q, expr_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             chk_q, chk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             cnt_clr, cnt_inc, cnt_hit;

  ivl_uvm_ovl_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .max_i  (max_q),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    expr_d  = expr_q;
    load_d  = load_q;
    step_d  = step_q;
    max_d   = max_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        chk_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          // Run parameters are captured here so later input changes cannot
          // disturb a run in progress.
          load_d  = bus.load_val;
          step_d  = bus.step;
          max_d   = bus.max_steps;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Jump to the start value is not a decrement: keep the checker off.
        expr_d  = load_q;
        chk_d   = 1'b0;
        state_d = COUNT;
      end
      COUNT: begin
        if (bus.abort) begin
          chk_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if ((expr_q == '0) || cnt_hit) begin
          chk_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (bus.pause) begin
          // A held value is a legal step for the checker.
          chk_d = 1'b1;
        end else if (expr_q >= step_q) begin
          expr_d  = expr_q - step_q;
          chk_d   = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          // Underflow: the change is not a plain decrement, so mask it.
          chk_d   = 1'b0;
          cnt_inc = 1'b1;
          if (WRAP != 0) begin
            expr_d = expr_q - step_q;
            wrap_d = 1'b1;
          end else begin
            expr_d = '0;
          end
        end
      end
      DONE: begin
        chk_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      expr_q  <= '0;
      load_q  <= '0;
      step_q  <= '0;
      max_q   <= '0;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      expr_q  <= expr_d;
      load_q  <= load_d;
      step_q  <= step_d;
      max_q   <= max_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.expr       = expr_q;
  assign bus.chk_enable = chk_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wrapped    = wrap_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ivl_uvm_ovl_dec_ctrl
// Two sequencer instances (saturating and wrapping). Each run is turned into
// an expected per-cycle output trace by a behavioural model and queued; a
// monitor per instance pops one entry per clock and compares, and expects
// quiet idle outputs whenever its queue is empty.
// ---------------------------------------------------------------------------
module tb_ivl_uvm_ovl_dec_ctrl;

  typedef struct packed {
    logic [3:0] expr;
    logic       chk;
    logic       busy;
    logic       done;
    logic       wr;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ivl_uvm_ovl_dec_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
  ivl_uvm_ovl_dec_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus1 ();

  ivl_uvm_ovl_dec_ctrl #(.WIDTH(4), .CNT_W(8), .WRAP(0)) u_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  ivl_uvm_ovl_dec_ctrl #(.WIDTH(4), .CNT_W(8), .WRAP(1)) u_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  ent_t       q0[$];
  ent_t       q1[$];
  logic [3:0] last0 = 4'd0;
  logic [3:0] last1 = 4'd0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(input int ex, input bit c, input bit b, input bit dn, input bit w);
    ent_t e;
    e.expr = 4'(ex);
    e.chk  = c;
    e.busy = b;
    e.done = dn;
    e.wr   = w;
    return e;
  endfunction

  task automatic push(input int d, input ent_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected outputs after each edge from the start edge onward.
  // k counts the edges spent counting; pause covers k in [pa, pa+pl).
  task automatic build(input int d, input int ld, input int st, input int mx,
                       input int pa, input int pl, input int ab, output int n);
    int v;
    int cnt;
    v   = ld;
    cnt = 0;
    push(d, mk((d == 0) ? int'(last0) : int'(last1), 0, 1, 0, 0));
    push(d, mk(ld, 0, 1, 0, 0));
    n = 2;
    for (int k = 0; k < 300; k++) begin
      if (k == ab) begin
        push(d, mk(v, 0, 0, 0, 0));
        n++;
        break;
      end
      if (v == 0 || (mx != 0 && cnt == mx)) begin
        push(d, mk(v, 0, 0, 1, 0));
        n++;
        break;
      end
      if (k >= pa && k < pa + pl) begin
        push(d, mk(v, 1, 1, 0, 0));
      end else begin
        if (cnt < 255) cnt++;
        if (v >= st) begin
          v = v - st;
          push(d, mk(v, 1, 1, 0, 0));
        end else if (d == 0) begin
          v = 0;
          push(d, mk(v, 0, 1, 0, 0));
        end else begin
          v = v + 16 - st;
          push(d, mk(v, 0, 1, 0, 1));
        end
      end
      n++;
    end
  endtask

  task automatic drive(input int d, input bit s, input bit p, input bit a,
                       input int ld, input int st, input int mx);
    if (d == 0) begin
      bus0.start = s; bus0.pause = p; bus0.abort = a;
      bus0.load_val = 4'(ld); bus0.step = 4'(st); bus0.max_steps = 8'(mx);
    end else begin
      bus1.start = s; bus1.pause = p; bus1.abort = a;
      bus1.load_val = 4'(ld); bus1.step = 4'(st); bus1.max_steps = 8'(mx);
    end
  endtask

  // ms: edge index carrying an extra start pulse; rs: edge index before
  // which reset is pulled low asynchronously (-1 for none).
  task automatic run(input int d, input int ld, input int st, input int mx,
                     input int pa, input int pl, input int ab, input int ms, input int rs);
    int  n;
    logic [7:0] act;
    @(negedge clock);
    build(d, ld, st, mx, pa, pl, ab, n);
    for (int i = 0; i < n; i++) begin
      drive(d, (i == 0) || (i == ms),
            (i >= 2) && (i - 2 >= pa) && (i - 2 < pa + pl),
            (i >= 2) && (i - 2 == ab), ld, st, mx);
      if (i == rs) begin
        #2;
        reset = 1'b0;
        #1;
        act = (d == 0) ? {bus0.expr, bus0.chk_enable, bus0.busy, bus0.done, bus0.wrapped}
                       : {bus1.expr, bus1.chk_enable, bus1.busy, bus1.done, bus1.wrapped};
        check("async_reset_outputs", int'(act), 0);
        drive(d, 0, 0, 0, 0, 0, 0);
        q0.delete();
        q1.delete();
        last0 = 4'd0;
        last1 = 4'd0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        return;
      end
      @(negedge clock);
    end
    drive(d, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    if (d == 0 && q0.size() != 0) begin
      check("drain_q0", q0.size(), 0);
      q0.delete();
    end
    if (d == 1 && q1.size() != 0) begin
      check("drain_q1", q1.size(), 0);
      q1.delete();
    end
  endtask

  // Monitors: one entry per clock, idle expectation when nothing is queued.
  initial begin
    ent_t e;
    forever begin
      @(posedge clock);
      #1;
      e = '0;
      e.expr = last0;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        last0 = e.expr;
      end
      check("sat_outputs(expr,chk,busy,done,wrapped)",
            int'({bus0.expr, bus0.chk_enable, bus0.busy, bus0.done, bus0.wrapped}), int'(e));
    end
  end

  initial begin
    ent_t e;
    forever begin
      @(posedge clock);
      #1;
      e = '0;
      e.expr = last1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        last1 = e.expr;
      end
      check("wrap_outputs(expr,chk,busy,done,wrapped)",
            int'({bus1.expr, bus1.chk_enable, bus1.busy, bus1.done, bus1.wrapped}), int'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, ld, st, mx, pa, pl, ab, ms;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("reset_sat", int'({bus0.expr, bus0.chk_enable, bus0.busy, bus0.done, bus0.wrapped}), 0);
    check("reset_wrap", int'({bus1.expr, bus1.chk_enable, bus1.busy, bus1.done, bus1.wrapped}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run(0, 8, 1, 0, -1, 0, -1, -1, -1);   // basic 8..0
    run(0, 7, 3, 0, -1, 0, -1, -1, -1);   // saturate 7,4,1,0
    run(1, 2, 3, 3, -1, 0, -1, -1, -1);   // wrap 2,15,12,9 then budget
    run(0, 5, 1, 0, 2, 3, -1, 4, -1);     // pause at 3, stray start
    run(0, 10, 1, 0, -1, 0, 4, -1, -1);   // abort at 6
    run(0, 10, 1, 0, -1, 0, -1, -1, 6);   // reset mid-run
    run(0, 4, 0, 5, -1, 0, -1, -1, -1);   // step 0, budget 5
    run(1, 0, 5, 0, -1, 0, -1, -1, -1);   // zero start value finishes at once
    run(1, 3, 0, 0, -1, 0, 6, -1, -1);    // step 0 unlimited, only abort ends it

    for (int r = 0; r < 30; r++) begin
      d  = int'($urandom_range(0, 1));
      ld = int'($urandom_range(0, 15));
      st = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      mx = int'($urandom_range(0, 6));
      if ((st == 0 || d == 1) && mx == 0) mx = int'($urandom_range(1, 8));
      pa = int'($urandom_range(0, 5));
      pl = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      ms = int'($urandom_range(1, 6));
      run(d, ld, st, mx, pa, pl, ab, ms, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
